// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for the single SDRAM request port: A (video) high priority, B (SD) low priority.
// Build option ARB_ROUND_ROBIN_EN swaps the fixed-priority/starvation guard for simple alternation.
module ram_port_arbiter #(
  parameter int AddrWidth = 25,
  parameter int BStarve   = 8
) (
  input  logic                 Clk,
  input  logic                 nReset,
  input  logic [AddrWidth-1:0] A_Address,
  input  logic [31:0]          A_DataWrite,
  input  logic [1:0]           A_DataSize,
  input  logic                 A_ReadWrite,
  input  logic                 A_Request,
  output logic                 A_Ready,
  output logic [31:0]          A_DataRead,
  input  logic [AddrWidth-1:0] B_Address,
  input  logic [31:0]          B_DataWrite,
  input  logic [1:0]           B_DataSize,
  input  logic                 B_ReadWrite,
  input  logic                 B_Request,
  output logic                 B_Ready,
  output logic [31:0]          B_DataRead,
  output logic [AddrWidth-1:0] Address,
  output logic [31:0]          DataWrite,
  output logic [1:0]           DataSize,
  output logic                 ReadWrite,
  output logic                 Request,
  input  logic                 Ready,
  input  logic [31:0]          DataRead,
  output logic [1:0]           Grant
);
  localparam int NUM_PORTS = 2;
  localparam int CntW      = (BStarve > 0) ? $clog2(BStarve + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_ACCEPT,
    S_DONE,
    S_RELEASE
  } state_t;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [31:0]          wdata;
    logic [1:0]           size;
    logic                 rw;
  } cmd_t;

  state_t                     state_q, state_d;
  cmd_t [NUM_PORTS-1:0]       cmd_in;
  cmd_t                       cmd_win;
  logic [NUM_PORTS-1:0]       port_rdy;
  logic [NUM_PORTS-1:0][31:0] port_rd;
  logic                       pick_b, own_req;
  logic                       latch_cmd, set_req, clr_req, load_rd, release_port;

  assign cmd_in[0] = {A_Address, A_DataWrite, A_DataSize, A_ReadWrite};
  assign cmd_in[1] = {B_Address, B_DataWrite, B_DataSize, B_ReadWrite};
  assign cmd_win   = pick_b ? cmd_in[1] : cmd_in[0];
  assign own_req   = Grant[1] ? B_Request : A_Request;

`ifdef ARB_ROUND_ROBIN_EN
  // Last-served flag starts at B so A is first out of reset; lone requests also update it.
  logic last_b_q;

  assign pick_b = B_Request && (!A_Request || !last_b_q);

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset)        last_b_q <= 1'b1;
    else if (latch_cmd) last_b_q <= pick_b;
  end
`else
  // Counts A grants made over a pending B; once saturated at BStarve, B takes the next slot.
  logic [CntW-1:0] starve_q;
  logic            starve_hit;

  assign starve_hit = (BStarve != 0) && (starve_q == CntW'(BStarve));
  assign pick_b     = B_Request && (!A_Request || starve_hit);

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      starve_q <= '0;
    end else if (state_q == S_IDLE) begin
      if (!B_Request || (latch_cmd && pick_b))
        starve_q <= '0;
      else if (latch_cmd && (starve_q != CntW'(BStarve)))
        starve_q <= starve_q + 1'b1;
    end
  end
`endif

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    latch_cmd    = 1'b0;
    set_req      = 1'b0;
    clr_req      = 1'b0;
    load_rd      = 1'b0;
    release_port = 1'b0;
    unique case (state_q)
      S_IDLE: if (A_Request || B_Request) begin
        latch_cmd = 1'b1;
        state_d   = S_ISSUE;
      end
      S_ISSUE: if (Ready) begin
        set_req = 1'b1;
        state_d = S_ACCEPT;
      end
      S_ACCEPT: if (!Ready) begin
        clr_req = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: if (Ready) begin
        load_rd = !ReadWrite;
        state_d = S_RELEASE;
      end
      // Hold the grant until the owner has withdrawn its request.
      S_RELEASE: if (!own_req) begin
        release_port = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      Address   <= '0;
      DataWrite <= '0;
      DataSize  <= '0;
      ReadWrite <= 1'b0;
      Request   <= 1'b0;
      Grant     <= 2'b00;
    end else begin
      if (latch_cmd) begin
        {Address, DataWrite, DataSize, ReadWrite} <= cmd_win;
        Grant <= pick_b ? 2'b10 : 2'b01;
      end
      if (set_req)      Request <= 1'b1;
      else if (clr_req) Request <= 1'b0;
      if (release_port) Grant <= 2'b00;
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    logic        grab, load, rel, rdy_q;
    logic [31:0] rd_q;

    assign grab = latch_cmd && ((i == 0) ? !pick_b : pick_b);
    assign load = load_rd && Grant[i];
    assign rel  = release_port && Grant[i];

    always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
        rdy_q <= 1'b1;
        rd_q  <= '0;
      end else begin
        if (grab)     rdy_q <= 1'b0;
        else if (rel) rdy_q <= 1'b1;
        if (load)     rd_q  <= DataRead;
      end
    end

    assign port_rdy[i] = rdy_q;
    assign port_rd[i]  = rd_q;
  end

  assign A_Ready    = port_rdy[0];
  assign B_Ready    = port_rdy[1];
  assign A_DataRead = port_rd[0];
  assign B_DataRead = port_rd[1];

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: backlogged masters, a latency-randomised RAM model,
// and a transaction-level arbitration model that predicts grant order and read data.
`timescale 1ns/1ps
module tb_ram_port_arbiter;
  localparam int AW = 25;
  localparam int BS = 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [1:0]    size;
    logic          rw;
  } mcmd_t;

  typedef struct packed {
    logic [1:0] grant;
    mcmd_t      cmd;
  } ram_cmd_t;

  logic          Clk = 1'b0, nReset = 1'b0;
  logic [AW-1:0] A_Address = '0, B_Address = '0, Address;
  logic [31:0]   A_DataWrite = '0, B_DataWrite = '0, A_DataRead, B_DataRead, DataWrite, DataRead;
  logic [1:0]    A_DataSize = '0, B_DataSize = '0, DataSize, Grant;
  logic          A_ReadWrite = 1'b0, B_ReadWrite = 1'b0, A_Request = 1'b0, B_Request = 1'b0;
  logic          A_Ready, B_Ready, ReadWrite, Request, Ready;

  always #5 Clk = ~Clk;

  ram_port_arbiter #(.AddrWidth(AW), .BStarve(BS)) dut (
    .Clk(Clk), .nReset(nReset),
    .A_Address(A_Address), .A_DataWrite(A_DataWrite), .A_DataSize(A_DataSize),
    .A_ReadWrite(A_ReadWrite), .A_Request(A_Request), .A_Ready(A_Ready), .A_DataRead(A_DataRead),
    .B_Address(B_Address), .B_DataWrite(B_DataWrite), .B_DataSize(B_DataSize),
    .B_ReadWrite(B_ReadWrite), .B_Request(B_Request), .B_Ready(B_Ready), .B_DataRead(B_DataRead),
    .Address(Address), .DataWrite(DataWrite), .DataSize(DataSize), .ReadWrite(ReadWrite),
    .Request(Request), .Ready(Ready), .DataRead(DataRead), .Grant(Grant)
  );

  int          total = 0, bad = 0;
  ram_cmd_t    exp_ram[$];
  logic [31:0] exp_a[$], exp_b[$];
  mcmd_t       stim_a[$], stim_b[$];
  logic [31:0] ram_mem[int];
  logic [31:0] shadow[int];
  bit          busy_a = 0, busy_b = 0;
  int          lat_fixed = 0;
  bit          m_last_b = 1'b1;
  logic [31:0] m_rd_a = '0, m_rd_b = '0;

  function automatic logic [31:0] mem_init(input logic [AW-1:0] a);
    return {7'h35, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic finish_sim();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  // Masters: one command at a time, request held until Ready drops, done when Ready returns.
  initial begin
    mcmd_t c;
    forever begin
      @(negedge Clk);
      if (!nReset) begin
        busy_a = 0; A_Request = 1'b0;
      end else begin
        if (busy_a && !A_Request && A_Ready) busy_a = 0;
        if (busy_a && A_Request && !A_Ready) A_Request = 1'b0;
        if (!busy_a && A_Ready && stim_a.size() > 0) begin
          c = stim_a.pop_front();
          {A_Address, A_DataWrite, A_DataSize, A_ReadWrite} = c;
          A_Request = 1'b1; busy_a = 1;
        end
      end
    end
  end

  initial begin
    mcmd_t c;
    forever begin
      @(negedge Clk);
      if (!nReset) begin
        busy_b = 0; B_Request = 1'b0;
      end else begin
        if (busy_b && !B_Request && B_Ready) busy_b = 0;
        if (busy_b && B_Request && !B_Ready) B_Request = 1'b0;
        if (!busy_b && B_Ready && stim_b.size() > 0) begin
          c = stim_b.pop_front();
          {B_Address, B_DataWrite, B_DataSize, B_ReadWrite} = c;
          B_Request = 1'b1; busy_b = 1;
        end
      end
    end
  end

  // RAM controller model; checks every accepted command against the predicted order.
  initial begin
    int            ram_busy, ram_hold;
    logic [AW-1:0] cur_addr;
    logic          cur_rw;
    ram_cmd_t      got;
    ram_busy = 0; ram_hold = 0; cur_addr = '0; cur_rw = 1'b0;
    Ready = 1'b1; DataRead = '0;
    forever begin
      @(posedge Clk); #1;
      if (!nReset) begin
        ram_busy = 0; ram_hold = 4; Ready = 1'b0;
      end else if (ram_hold > 0) begin
        ram_hold--;
        if (ram_hold == 0) Ready = 1'b1;
      end else if (ram_busy > 0) begin
        ram_busy--;
        if (ram_busy == 0) begin
          if (cur_rw) DataRead = $urandom;
          else DataRead = ram_mem.exists(int'(cur_addr)) ? ram_mem[int'(cur_addr)] : mem_init(cur_addr);
          Ready = 1'b1;
        end
      end else if (Request && Ready) begin
        got = {Grant, Address, DataWrite, DataSize, ReadWrite};
        if (exp_ram.size() == 0) begin
          total++; bad++;
          $display("FAIL ram_cmd: got unexpected command %0h, expected none", got);
        end else begin
          check("ram_cmd", 64'(got), 64'(exp_ram.pop_front()));
        end
        check("other_port_ready", 64'((Grant == 2'b01) ? B_Ready : A_Ready), 64'(1));
        cur_addr = Address; cur_rw = ReadWrite;
        if (ReadWrite) ram_mem[int'(Address)] = DataWrite;
        Ready = 1'b0;
        ram_busy = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 4));
      end
    end
  end

  // Completion monitor: a port's Ready returning high ends its transaction.
  initial begin
    logic pa, pb;
    pa = 1'b1; pb = 1'b1;
    forever begin
      @(negedge Clk);
      if (!nReset) begin
        pa = 1'b1; pb = 1'b1;
      end else begin
        if (A_Ready && !pa) begin
          if (exp_a.size() == 0) begin
            total++; bad++; $display("FAIL a_done: got unexpected completion, expected none");
          end else check("a_dataread", 64'(A_DataRead), 64'(exp_a.pop_front()));
          check("a_release_grant", 64'(Grant), 64'(0));
        end
        if (B_Ready && !pb) begin
          if (exp_b.size() == 0) begin
            total++; bad++; $display("FAIL b_done: got unexpected completion, expected none");
          end else check("b_dataread", 64'(B_DataRead), 64'(exp_b.pop_front()));
          check("b_release_grant", 64'(Grant), 64'(0));
        end
        pa = A_Ready; pb = B_Ready;
      end
    end
  end

  function automatic mcmd_t rand_cmd();
    mcmd_t c;
    c.addr  = AW'(4 * $urandom_range(0, 7));
    c.wdata = $urandom;
    c.size  = 2'($urandom);
    c.rw    = 1'($urandom);
    return c;
  endfunction

  task automatic model_txn(input bit is_b, input mcmd_t c);
    logic [31:0] v;
    exp_ram.push_back({is_b ? 2'b10 : 2'b01, c});
    if (c.rw) begin
      shadow[int'(c.addr)] = c.wdata;
    end else begin
      v = shadow.exists(int'(c.addr)) ? shadow[int'(c.addr)] : mem_init(c.addr);
      if (is_b) m_rd_b = v; else m_rd_a = v;
    end
    if (is_b) exp_b.push_back(m_rd_b); else exp_a.push_back(m_rd_a);
    m_last_b = is_b;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_ram.size() > 0 || exp_a.size() > 0 || exp_b.size() > 0 || stim_a.size() > 0 ||
            stim_b.size() > 0 || busy_a || busy_b) && n < budget) begin
      @(posedge Clk); n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL %s: timed out with %0d ram/%0d a/%0d b still pending, expected 0",
               name, exp_ram.size(), exp_a.size(), exp_b.size());
      finish_sim();
    end
  endtask

  // Both masters start together and stay backlogged, so grant order follows from the rules alone.
  task automatic scenario(input string name, input mcmd_t ca[$], input mcmd_t cb[$]);
    int ia, ib, cnt;
    bit ap, bp, pb;
    ia = 0; ib = 0; cnt = 0;
    while (ia < ca.size() || ib < cb.size()) begin
      ap = ia < ca.size();
      bp = ib < cb.size();
`ifdef ARB_ROUND_ROBIN_EN
      pb = bp && (!ap || !m_last_b);
`else
      pb = bp && (!ap || (BS != 0 && cnt >= BS));
      if (pb || !bp) cnt = 0;
      else if (cnt < BS) cnt++;
`endif
      if (pb) begin model_txn(1'b1, cb[ib]); ib++; end
      else    begin model_txn(1'b0, ca[ia]); ia++; end
    end
    foreach (ca[i]) stim_a.push_back(ca[i]);
    foreach (cb[i]) stim_b.push_back(cb[i]);
    wait_drain(name, 4000);
    repeat (3) @(posedge Clk);
    #2;
  endtask

  initial begin
    mcmd_t qa[$], qb[$], c;
    int    n;
    #12;
    check("rst_a_ready", 64'(A_Ready), 64'(1));
    check("rst_b_ready", 64'(B_Ready), 64'(1));
    check("rst_request", 64'(Request), 64'(0));
    check("rst_grant", 64'(Grant), 64'(0));
    check("rst_cmd", 64'({Address, DataWrite, DataSize, ReadWrite}), 64'(0));
    check("rst_dataread", 64'({A_DataRead, B_DataRead}), 64'(0));
    ram_mem[32'h100] = 32'hDEADBEEF;
    shadow[32'h100]  = 32'hDEADBEEF;
    @(posedge Clk); #3 nReset = 1'b1;
    @(posedge Clk); #2;

    lat_fixed = 3;
    qa = '{}; qb = '{};
    qa.push_back('{addr: AW'('h100), wdata: 32'h0, size: 2'b11, rw: 1'b0});
    scenario("a_read", qa, qb);
    qa = '{};
    qb.push_back('{addr: AW'('h4), wdata: 32'h11223344, size: 2'b11, rw: 1'b1});
    scenario("b_write", qa, qb);
    lat_fixed = 0;

    qa = '{rand_cmd()}; qb = '{rand_cmd()};
    scenario("same_cycle", qa, qb);

    qa = '{}; qb = '{};
    for (int i = 0; i < 20; i++) qa.push_back(rand_cmd());
    for (int i = 0; i < 3; i++)  qb.push_back(rand_cmd());
    scenario("starve", qa, qb);

    for (int s = 0; s < 8; s++) begin
      qa = '{}; qb = '{};
      n = $urandom_range(0, 12);
      for (int i = 0; i < n; i++) qa.push_back(rand_cmd());
      n = $urandom_range(0, 4);
      for (int i = 0; i < n; i++) qb.push_back(rand_cmd());
      scenario("random", qa, qb);
    end

    // Abandon an A read mid-flight with reset while the controller is in ACCEPT.
    c = '{addr: AW'('h40), wdata: 32'h1, size: 2'b11, rw: 1'b0};
    exp_ram.push_back({2'b01, c});
    stim_a.push_back(c);
    n = 0;
    do begin @(posedge Clk); #3; n++; end while (!Request && n < 50);
    if (!Request) begin
      total++; bad++;
      $display("FAIL reset_setup: Request got 0, expected 1 within 50 cycles");
      finish_sim();
    end
    nReset = 1'b0;
    #1;
    check("mid_rst_request", 64'(Request), 64'(0));
    check("mid_rst_grant", 64'(Grant), 64'(0));
    check("mid_rst_readies", 64'({A_Ready, B_Ready}), 64'(2'b11));
    check("mid_rst_dataread", 64'(A_DataRead), 64'(0));
    check("mid_rst_cmd_consumed", 64'(exp_ram.size()), 64'(0));
    exp_ram.delete(); exp_a.delete(); exp_b.delete();
    m_rd_a = '0; m_rd_b = '0; m_last_b = 1'b1;
    repeat (2) @(posedge Clk);
    #3 nReset = 1'b1;
    @(posedge Clk); #2;

    qa = '{'{addr: AW'('h100), wdata: 32'h0, size: 2'b11, rw: 1'b0}}; qb = '{};
    scenario("post_reset_read", qa, qb);
    for (int s = 0; s < 2; s++) begin
      qa = '{}; qb = '{};
      for (int i = 0; i < 5; i++) qa.push_back(rand_cmd());
      for (int i = 0; i < 3; i++) qb.push_back(rand_cmd());
      scenario("post_reset_mix", qa, qb);
    end
    finish_sim();
  end

  initial begin
    #2000000;
    total++; bad++;
    $display("FAIL watchdog: simulation got past 2 ms, expected to finish earlier");
    finish_sim();
  end

endmodule
